// File: rtl/pe_stream_pkg.sv
// Shared types and constants for the PE stream driver: FSM states, default
// widths and the fixed-point formats of the operands and accumulator.
package pe_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 16;
    localparam int unsigned DEF_WEIGHT_WIDTH = 8;
    localparam int unsigned DEF_ACCUM_WIDTH  = 32;
    localparam int unsigned DEF_LEN_WIDTH    = 8;

    // Binary point positions: S5.10 activations, S1.6 weights, S15.16 accumulator.
    localparam int unsigned DATA_FRAC   = 10;
    localparam int unsigned WEIGHT_FRAC = 6;
    localparam int unsigned ACCUM_FRAC  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_WAIT,
        ST_RESULT
    } state_e;

endpackage

// File: rtl/pe_stream_driver.sv
// Job-level transmitter for one processing element: streams K operand pairs in,
// sequences the accumulator clear, and returns the PE's final dot product.
module pe_stream_driver
    import pe_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int unsigned ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
    parameter int unsigned LEN_WIDTH    = DEF_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    vec_len,
    output logic                    busy,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic [WEIGHT_WIDTH-1:0] s_weight,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   pe_data_out,
    output logic                    pe_data_valid,
    output logic [WEIGHT_WIDTH-1:0] pe_weight_out,
    output logic                    pe_weight_valid,
    output logic                    pe_clear_accum,
    input  logic [ACCUM_WIDTH-1:0]  pe_accum_in,
    input  logic                    pe_result_valid_in,
    output logic [ACCUM_WIDTH-1:0]  res_data,
    output logic                    res_valid,
    input  logic                    res_ready
);

    state_e                  state_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_cnt_q;
    logic [LEN_WIDTH-1:0]    beat_cnt_d;
    logic [LEN_WIDTH-1:0]    res_cnt_q;
    logic [LEN_WIDTH-1:0]    res_cnt_d;
    logic [DATA_WIDTH-1:0]   pe_data_q;
    logic [WEIGHT_WIDTH-1:0] pe_weight_q;
    logic                    pe_valid_q;
    logic                    clear_q;
    logic [ACCUM_WIDTH-1:0]  res_data_q;
    logic                    res_valid_q;
    logic                    accept;

    assign beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
    assign res_cnt_d  = res_cnt_q + LEN_WIDTH'(1);

    // Ready depends only on registered state, never on s_valid.
    assign s_ready = (state_q == ST_STREAM) && (beat_cnt_q < len_q);
    assign accept  = s_valid && s_ready;
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            res_cnt_q   <= '0;
            pe_data_q   <= '0;
            pe_weight_q <= '0;
            pe_valid_q  <= 1'b0;
            clear_q     <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            // Any cycle without an accept presents a zeroed bubble to the PE.
            pe_data_q   <= '0;
            pe_weight_q <= '0;
            pe_valid_q  <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (start && (vec_len != '0)) begin
                        len_q      <= vec_len;
                        beat_cnt_q <= '0;
                        res_cnt_q  <= '0;
                        clear_q    <= 1'b1;
                        state_q    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept) begin
                        pe_data_q   <= s_data;
                        pe_weight_q <= s_weight;
                        pe_valid_q  <= 1'b1;
                        clear_q     <= 1'b0;
                        beat_cnt_q  <= beat_cnt_d;
                        if (beat_cnt_d == len_q) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    if (pe_result_valid_in) begin
                        res_cnt_q <= res_cnt_d;
                    end
                end
                ST_WAIT: begin
                    if (pe_result_valid_in) begin
                        res_cnt_q <= res_cnt_d;
                        if (res_cnt_d == len_q) begin
                            res_data_q  <= pe_accum_in;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pe_data_out     = pe_data_q;
    assign pe_weight_out   = pe_weight_q;
    assign pe_data_valid   = pe_valid_q;
    assign pe_weight_valid = pe_valid_q;
    assign pe_clear_accum  = clear_q;
    assign res_data        = res_data_q;
    assign res_valid       = res_valid_q;

endmodule

// File: tb/tb_pe_stream_driver.sv
// Bench for pe_stream_driver: a behavioural PE load, directed job scenarios and
// randomized jobs checked against an arithmetic dot-product reference.
module tb_pe_stream_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  vec_len;
    logic        busy;
    logic [15:0] s_data;
    logic [7:0]  s_weight;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] pe_data_out;
    logic        pe_data_valid;
    logic [7:0]  pe_weight_out;
    logic        pe_weight_valid;
    logic        pe_clear_accum;
    logic [31:0] pe_accum_in;
    logic        pe_result_valid_in;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;

    int total = 0;
    int bad   = 0;

    logic [15:0] pd [0:255];
    logic [7:0]  pw [0:255];

    logic [23:0] mon_q [$];
    bit          mon_clr_q [$];
    int          bubble_bad = 0;
    bit          prev_clr = 1'b0;

    pe_stream_driver #(
        .DATA_WIDTH  (16),
        .WEIGHT_WIDTH(8),
        .ACCUM_WIDTH (32),
        .LEN_WIDTH   (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .vec_len           (vec_len),
        .busy              (busy),
        .s_data            (s_data),
        .s_weight          (s_weight),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .pe_data_out       (pe_data_out),
        .pe_data_valid     (pe_data_valid),
        .pe_weight_out     (pe_weight_out),
        .pe_weight_valid   (pe_weight_valid),
        .pe_clear_accum    (pe_clear_accum),
        .pe_accum_in       (pe_accum_in),
        .pe_result_valid_in(pe_result_valid_in),
        .res_data          (res_data),
        .res_valid         (res_valid),
        .res_ready         (res_ready)
    );

    always #5 clk = ~clk;

    // Processing element load: registered clear, signed MAC, one result pulse per pair.
    logic signed [31:0] pe_acc;
    logic signed [31:0] pe_da;
    logic signed [31:0] pe_wa;
    logic               pe_clr_q;
    logic               pe_rv;
    assign pe_da = $signed(pe_data_out);
    assign pe_wa = $signed(pe_weight_out);
    assign pe_accum_in        = pe_acc;
    assign pe_result_valid_in = pe_rv;

    always @(posedge clk) begin
        if (!rst_n) begin
            pe_acc   <= '0;
            pe_clr_q <= 1'b0;
            pe_rv    <= 1'b0;
        end else begin
            pe_clr_q <= pe_clear_accum;
            pe_rv    <= pe_data_valid && pe_weight_valid;
            pe_acc   <= (pe_clr_q ? 32'sd0 : pe_acc)
                        + ((pe_data_valid && pe_weight_valid) ? pe_da * pe_wa : 32'sd0);
        end
    end

    // Record every pair presented to the PE and whether clear was high the cycle before.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pe_data_valid) begin
                mon_q.push_back({pe_data_out, pe_weight_out});
                mon_clr_q.push_back(prev_clr);
            end
            if (pe_data_valid !== pe_weight_valid ||
                (!pe_data_valid && (pe_data_out !== 16'h0 || pe_weight_out !== 8'h0)))
                bubble_bad++;
            prev_clr = pe_clear_accum;
        end else begin
            prev_clr = 1'b0;
        end
    end

    function automatic logic [31:0] ref_dot(input int k);
        longint s = 0;
        for (int i = 0; i < k; i++)
            s += longint'($signed(pd[i])) * longint'($signed(pw[i]));
        return s[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_job(input int k, input int bub, input bit rnd, output bit ok);
        int idx = 0;
        int gap = 0;
        int cyc = 0;
        bit rdy;
        mon_q.delete();
        mon_clr_q.delete();
        bubble_bad = 0;
        start   = 1'b1;
        vec_len = 8'(k);
        step();
        start = 1'b0;
        while (idx < k && cyc < 4000) begin
            if (gap > 0) begin
                s_valid  = 1'b0;
                s_data   = 16'($urandom);
                s_weight = 8'($urandom);
                gap--;
            end else begin
                s_valid  = 1'b1;
                s_data   = pd[idx];
                s_weight = pw[idx];
            end
            rdy = s_ready;
            step();
            cyc++;
            if (s_valid && rdy) begin
                idx++;
                gap = rnd ? int'($urandom_range(0, bub)) : bub;
            end
        end
        s_valid = 1'b0;
        while (!res_valid && cyc < 4000) begin
            step();
            cyc++;
        end
        ok = (idx == k) && res_valid;
    endtask

    task automatic finish_job();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({busy, s_ready, pe_data_out, pe_data_valid, pe_weight_out, pe_weight_valid,
             pe_clear_accum, res_data, res_valid} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b rdy=%b d=%h dv=%b w=%h wv=%b clr=%b res=%h rv=%b, all required 0",
                     busy, s_ready, pe_data_out, pe_data_valid, pe_weight_out, pe_weight_valid,
                     pe_clear_accum, res_data, res_valid);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        logic [31:0] exp;
        pd[0] = 16'h1400; pw[0] = 8'h40;
        exp = ref_dot(1);
        start = 1'b1; vec_len = 8'd1;
        step();
        start = 1'b0;
        total++;
        if ({busy, pe_clear_accum, s_ready} !== 3'b110) begin
            bad++; $display("FAIL single_clear_cycle: busy,clr,rdy=%b want 110", {busy, pe_clear_accum, s_ready});
        end
        step();
        total++;
        if ({s_ready, pe_clear_accum} !== 2'b11) begin
            bad++; $display("FAIL single_stream_entry: rdy,clr=%b want 11", {s_ready, pe_clear_accum});
        end
        s_valid = 1'b1; s_data = pd[0]; s_weight = pw[0];
        step();
        s_valid = 1'b0;
        total++;
        if ({pe_data_valid, pe_weight_valid, pe_data_out, pe_weight_out, pe_clear_accum, s_ready}
            !== {2'b11, 16'h1400, 8'h40, 2'b00}) begin
            bad++;
            $display("FAIL single_presented: dv=%b wv=%b d=%h w=%h clr=%b rdy=%b want 1 1 1400 40 0 0",
                     pe_data_valid, pe_weight_valid, pe_data_out, pe_weight_out, pe_clear_accum, s_ready);
        end
        step();
        total++;
        if ({pe_result_valid_in, res_valid, pe_data_valid} !== 3'b100) begin
            bad++; $display("FAIL single_pulse_cycle: pulse,rv,dv=%b want 100", {pe_result_valid_in, res_valid, pe_data_valid});
        end
        step();
        total++;
        if (res_valid !== 1'b1 || res_data !== exp || exp !== 32'h0005_0000) begin
            bad++; $display("FAIL single_result: rv=%b res=%h want 1 %h", res_valid, res_data, exp);
        end
        finish_job();
        total++;
        if ({res_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL single_handshake: rv,busy=%b want 00", {res_valid, busy});
        end
    endtask

    task automatic test_bubbles();
        bit ok;
        logic [31:0] exp;
        pd[0] = 16'h1400; pw[0] = 8'h40;
        pd[1] = 16'h0800; pw[1] = 8'hC0;
        exp = ref_dot(2);
        send_job(2, 3, 1'b0, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL bubbles_timeout: res_valid=%b want 1", res_valid); end
        total++;
        if (res_data !== exp || exp !== 32'h0003_0000) begin
            bad++; $display("FAIL bubbles_result: got %h want %h", res_data, exp);
        end
        total++;
        if (bubble_bad !== 0 || mon_q.size() !== 2 || mon_clr_q.size() !== 2) begin
            bad++; $display("FAIL bubbles_stream: bubble_errs=%0d beats=%0d want 0 2", bubble_bad, mon_q.size());
        end else begin
            total++;
            if (mon_q[0] !== 24'h1400_40 || mon_q[1] !== 24'h0800_C0 || mon_clr_q[0] !== 1'b1 || mon_clr_q[1] !== 1'b0) begin
                bad++; $display("FAIL bubbles_beats: got %h/%b %h/%b want 140040/1 0800c0/0",
                                mon_q[0], mon_clr_q[0], mon_q[1], mon_clr_q[1]);
            end
        end
        finish_job();
    endtask

    task automatic test_back_to_back();
        bit ok;
        pd[0] = 16'h1400; pw[0] = 8'h40;
        pd[1] = 16'h0800; pw[1] = 8'hC0;
        send_job(2, 3, 1'b0, ok);
        total++;
        if (ok !== 1'b1 || res_data !== 32'h0003_0000) begin
            bad++; $display("FAIL b2b_job_a: ok=%b res=%h want 1 00030000", ok, res_data);
        end
        finish_job();
        pd[0] = 16'h0400; pw[0] = 8'h40;
        send_job(1, 0, 1'b0, ok);
        total++;
        if (ok !== 1'b1 || res_data !== 32'h0001_0000) begin
            bad++; $display("FAIL b2b_job_b: ok=%b res=%h want 1 00010000", ok, res_data);
        end
        finish_job();
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] exp;
        pd[0] = 16'($urandom); pw[0] = 8'($urandom);
        exp = ref_dot(1);
        send_job(1, 0, 1'b0, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL stall_timeout: res_valid=%b want 1", res_valid); end
        for (int c = 0; c < 5; c++) begin
            start = 1'b1; vec_len = 8'd3;
            step();
            total++;
            if ({res_valid, busy} !== 2'b11 || res_data !== exp) begin
                bad++; $display("FAIL stall_hold[%0d]: rv,busy=%b res=%h want 11 %h", c, {res_valid, busy}, res_data, exp);
            end
        end
        start = 1'b0;
        finish_job();
        step();
        total++;
        if ({busy, res_valid} !== 2'b00) begin
            bad++; $display("FAIL stall_start_dropped: busy,rv=%b want 00", {busy, res_valid});
        end
    endtask

    task automatic test_zero_len();
        int rises = 0;
        start = 1'b1; vec_len = 8'd0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (busy !== 1'b0 || pe_clear_accum !== 1'b0) rises++;
        end
        start = 1'b0;
        total++;
        if (rises !== 0) begin bad++; $display("FAIL zero_len_busy: busy cycles=%0d want 0", rises); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] exp;
        start = 1'b1; vec_len = 8'd4;
        step();
        start = 1'b0;
        step();
        s_valid = 1'b1; s_data = 16'h1234; s_weight = 8'h21;
        step();
        s_valid = 1'b0;
        rst_n = 1'b0;
        step();
        total++;
        if ({busy, s_ready, pe_data_out, pe_data_valid, pe_weight_out, pe_weight_valid,
             pe_clear_accum, res_data, res_valid} !== '0) begin
            bad++; $display("FAIL midreset_outputs: busy=%b rdy=%b dv=%b clr=%b rv=%b, all required 0",
                            busy, s_ready, pe_data_valid, pe_clear_accum, res_valid);
        end
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin pd[i] = 16'($urandom); pw[i] = 8'($urandom); end
        exp = ref_dot(3);
        send_job(3, 2, 1'b1, ok);
        total++;
        if (ok !== 1'b1 || res_data !== exp) begin
            bad++; $display("FAIL midreset_next_job: ok=%b res=%h want 1 %h", ok, res_data, exp);
        end
        finish_job();
    endtask

    task automatic test_random();
        bit ok;
        int k;
        int errs;
        logic [31:0] exp;
        for (int j = 0; j < 20; j++) begin
            k = (j == 19) ? 255 : int'($urandom_range(1, 12));
            for (int i = 0; i < k; i++) begin pd[i] = 16'($urandom); pw[i] = 8'($urandom); end
            exp = ref_dot(k);
            send_job(k, (j == 19) ? 1 : 3, 1'b1, ok);
            errs = bubble_bad;
            if (mon_q.size() != k) errs++;
            else for (int i = 0; i < k; i++)
                if (mon_q[i] !== {pd[i], pw[i]} || mon_clr_q[i] !== (i == 0)) errs++;
            total++;
            if (ok !== 1'b1 || res_data !== exp) begin
                bad++; $display("FAIL random_result[%0d] K=%0d: ok=%b got %h want %h", j, k, ok, res_data, exp);
            end
            total++;
            if (errs !== 0) begin
                bad++; $display("FAIL random_stream[%0d] K=%0d: stream errors=%0d want 0", j, k, errs);
            end
            for (int c = int'($urandom_range(0, 3)); c > 0; c--) step();
            finish_job();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; vec_len = '0;
        s_valid = 1'b0; s_data = '0; s_weight = '0; res_ready = 1'b0;
        repeat (3) step();
        test_reset();
        test_single();
        test_bubbles();
        test_back_to_back();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
